// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the decode->execute pipeline register.
package id_ex_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  // Field offsets inside the packed decode control bundle
  localparam int CTRL_LOAD_BIT     = 0;
  localparam int CTRL_STORE_BIT    = 1;
  localparam int CTRL_REGW_BIT     = 2;
  localparam int CTRL_BRANCH_BIT   = 3;
  localparam int CTRL_ALUOP_LSB    = 4;
  localparam int CTRL_ALUOP_W      = 4;
  localparam int CTRL_SRCB_IMM_BIT = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  // Selects writeback data over a register-file read that races the same write
  function automatic logic [XLEN-1:0] bypass_sel(
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata,
    input logic [4:0]      idx,
    input logic [XLEN-1:0] val
  );
    return (we && (wrd != 5'd0) && (wrd == idx)) ? wdata : val;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Pipeline bus carrying one decoded instruction plus its valid/ready handshake.
interface id_ex_if;
  import id_ex_pkg::*;

  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   pc;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, rd1, rd2, rs1, rs2, rd, imm, pc, ctrl, input ready);
  modport slave  (input valid, rd1, rd2, rs1, rs2, rd, imm, pc, ctrl, output ready);

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the held load and the decoding instruction.
module load_use_detect (
  input  logic       i_valid_e,
  input  logic       i_is_load,
  input  logic [4:0] i_rd_e,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic       i_valid_d,
  output logic       o_hazard
);

  logic w_src_match;

  assign w_src_match = (i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d);
  // x0 is hardwired zero, so a load into it can never create a dependency
  assign o_hazard    = i_valid_e & i_is_load & (i_rd_e != 5'd0) & w_src_match & i_valid_d;

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with handshake, flush and load-use bubble insertion.
// Optional WB_BYPASS_EN: patch RD1/RD2 with same-cycle writeback data on capture and while held.
module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  id_ex_if.slave           i_dec,
  id_ex_if.master          o_ex,
  input  logic             flush_e,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  state_e            r_state_p0, w_state_nxt;
  logic              r_live;
  logic [XLEN-1:0]   r_rd1_p0, r_rd2_p0, r_imm_p0, r_pc_p0;
  logic [4:0]        r_rs1_p0, r_rs2_p0, r_rd_p0;
  logic [CTRL_W-1:0] r_ctrl_p0;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_valid_e, w_hazard, w_ready_d, w_accept;
  logic              w_capture, w_bubble;
  logic [XLEN-1:0]   w_rd1_cap, w_rd2_cap, w_rd1_hold, w_rd2_hold;

  assign w_valid_e = (r_state_p0 == FULL);

  load_use_detect u_load_use_detect (
    .i_valid_e (w_valid_e),
    .i_is_load (r_ctrl_p0[CTRL_LOAD_BIT]),
    .i_rd_e    (r_rd_p0),
    .i_rs1_d   (i_dec.rs1),
    .i_rs2_d   (i_dec.rs2),
    .i_valid_d (i_dec.valid),
    .o_hazard  (w_hazard)
  );

  // r_live keeps ready_d low until the first edge after reset release
  assign w_ready_d = r_live & ~w_hazard & (~w_valid_e | o_ex.ready);
  assign w_accept  = i_dec.valid & w_ready_d;

`ifdef WB_BYPASS_EN
  assign w_rd1_cap  = bypass_sel(wb_we, wb_rd, wb_data, i_dec.rs1, i_dec.rd1);
  assign w_rd2_cap  = bypass_sel(wb_we, wb_rd, wb_data, i_dec.rs2, i_dec.rd2);
  assign w_rd1_hold = bypass_sel(wb_we, wb_rd, wb_data, r_rs1_p0, r_rd1_p0);
  assign w_rd2_hold = bypass_sel(wb_we, wb_rd, wb_data, r_rs2_p0, r_rd2_p0);
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_we, wb_rd, wb_data};
  assign w_rd1_cap   = i_dec.rd1;
  assign w_rd2_cap   = i_dec.rd2;
  assign w_rd1_hold  = r_rd1_p0;
  assign w_rd2_hold  = r_rd2_p0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_p0   <= EMPTY;
      r_live       <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      r_state_p0 <= w_state_nxt;
      r_live     <= 1'b1;
      if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state_p0;
    w_capture   = 1'b0;
    w_bubble    = 1'b0;
    if (flush_e) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state_p0)
        EMPTY, BUBBLE: begin
          w_state_nxt = w_accept ? FULL : EMPTY;
          w_capture   = w_accept;
        end
        FULL: begin
          if (o_ex.ready) begin
            if (w_accept) begin
              w_state_nxt = FULL;
              w_capture   = 1'b1;
            end else if (w_hazard) begin
              w_state_nxt = BUBBLE;
              w_bubble    = 1'b1;
            end else begin
              w_state_nxt = EMPTY;
            end
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // ---- p0: decode fields captured into the execute-side register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd1_p0  <= '0;
      r_rd2_p0  <= '0;
      r_imm_p0  <= '0;
      r_pc_p0   <= '0;
      r_rs1_p0  <= '0;
      r_rs2_p0  <= '0;
      r_rd_p0   <= '0;
      r_ctrl_p0 <= '0;
    end else if (w_capture) begin
      r_rd1_p0  <= w_rd1_cap;
      r_rd2_p0  <= w_rd2_cap;
      r_imm_p0  <= i_dec.imm;
      r_pc_p0   <= i_dec.pc;
      r_rs1_p0  <= i_dec.rs1;
      r_rs2_p0  <= i_dec.rs2;
      r_rd_p0   <= i_dec.rd;
      r_ctrl_p0 <= i_dec.ctrl;
    end else begin
      r_rd1_p0  <= w_rd1_hold;
      r_rd2_p0  <= w_rd2_hold;
    end
  end

  assign i_dec.ready = w_ready_d;
  assign o_ex.valid  = w_valid_e;
  assign o_ex.rd1    = r_rd1_p0;
  assign o_ex.rd2    = r_rd2_p0;
  assign o_ex.imm    = r_imm_p0;
  assign o_ex.pc     = r_pc_p0;
  assign o_ex.rs1    = r_rs1_p0;
  assign o_ex.rs2    = r_rs2_p0;
  assign o_ex.rd     = r_rd_p0;
  assign o_ex.ctrl   = w_valid_e ? r_ctrl_p0 : '0;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, stall, load-use bubble, flush, writeback bypass, reset.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic             clk;
  logic             rst;
  logic             flush_e;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [CNT_W-1:0] bubble_cnt;

  int n_cmp;
  int n_err;

  id_ex_if dec ();
  id_ex_if ex ();

  id_ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .i_dec      (dec),
    .o_ex       (ex),
    .flush_e    (flush_e),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [15:0] ctrl, input logic [31:0] pc);
    dec.valid = v;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.rd    = rd;
    dec.rd1   = rd1;
    dec.rd2   = rd2;
    dec.imm   = ~rd1;
    dec.pc    = pc;
    dec.ctrl  = ctrl;
  endtask

  localparam logic [15:0] C_ALU  = 16'h0004;
  localparam logic [15:0] C_LOAD = 16'h0001;

  logic [31:0] exp_bp1, exp_bp2;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    flush_e  = 1'b0;
    wb_we    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    ex.ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 32'h0);
`ifdef WB_BYPASS_EN
    exp_bp1 = 32'hAB;
    exp_bp2 = 32'hCAFE;
`else
    exp_bp1 = 32'h0;
    exp_bp2 = 32'h9;
`endif

    // Reset state
    step();
    step();
    chk("rst_valid_e", {31'b0, ex.valid}, 32'd0);
    chk("rst_ready_d", {31'b0, dec.ready}, 32'd0);
    chk("rst_rd1_e", ex.rd1, 32'd0);
    chk("rst_ctrl_e", {16'b0, ex.ctrl}, 32'd0);
    chk("rst_bubble", {16'b0, bubble_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_d_low", {31'b0, dec.ready}, 32'd0);
    step();
    chk("rel_ready_d_high", {31'b0, dec.ready}, 32'd1);

    // Basic capture, one-cycle latency
    drive(1'b1, 5'd1, 5'd2, 5'd5, 32'h11, 32'h12, C_ALU, 32'h1000);
    step();
    chk("t1_valid_e", {31'b0, ex.valid}, 32'd1);
    chk("t1_rd1_e", ex.rd1, 32'h11);
    chk("t1_rd2_e", ex.rd2, 32'h12);
    chk("t1_rd_e", {27'b0, ex.rd}, 32'd5);
    chk("t1_rs_e", {22'b0, ex.rs1, ex.rs2}, {22'b0, 5'd1, 5'd2});
    chk("t1_imm_e", ex.imm, 32'hFFFF_FFEE);
    chk("t1_pc_e", ex.pc, 32'h1000);
    chk("t1_ctrl_e", {16'b0, ex.ctrl}, {16'b0, C_ALU});

    // Execute stall for three cycles
    drive(1'b1, 5'd3, 5'd4, 5'd6, 32'h22, 32'h23, 16'h0008, 32'h1004);
    ex.ready = 1'b0;
    #1;
    chk("t2_ready_d_stall", {31'b0, dec.ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_rd1", ex.rd1, 32'h11);
      chk("t2_hold_ctrl", {16'b0, ex.ctrl}, {16'b0, C_ALU});
      chk("t2_hold_valid", {31'b0, ex.valid}, 32'd1);
    end
    ex.ready = 1'b1;
    #1;
    chk("t2_ready_d_rel", {31'b0, dec.ready}, 32'd1);
    step();
    chk("t2_new_rd1", ex.rd1, 32'h22);
    chk("t2_new_rd", {27'b0, ex.rd}, 32'd6);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 32'h0);
    step();
    chk("t2_drain_valid", {31'b0, ex.valid}, 32'd0);
    chk("t2_drain_ctrl", {16'b0, ex.ctrl}, 32'd0);

    // Load-use: load into x7 followed by consumer on rs2
    drive(1'b1, 5'd1, 5'd2, 5'd7, 32'h33, 32'h0, C_LOAD, 32'h2000);
    step();
    chk("t3_load_valid", {31'b0, ex.valid}, 32'd1);
    drive(1'b1, 5'd8, 5'd7, 5'd9, 32'h44, 32'h45, C_ALU, 32'h2004);
    #1;
    chk("t3_ready_d_haz", {31'b0, dec.ready}, 32'd0);
    step();
    chk("t3_bubble_valid", {31'b0, ex.valid}, 32'd0);
    chk("t3_bubble_ctrl", {16'b0, ex.ctrl}, 32'd0);
    chk("t3_bubble_cnt", {16'b0, bubble_cnt}, 32'd1);
    chk("t3_ready_d_bub", {31'b0, dec.ready}, 32'd1);
    step();
    chk("t3_acc_valid", {31'b0, ex.valid}, 32'd1);
    chk("t3_acc_rd1", ex.rd1, 32'h44);
    chk("t3_acc_rd", {27'b0, ex.rd}, 32'd9);
    chk("t3_cnt_stable", {16'b0, bubble_cnt}, 32'd1);

    // Load into x0 never stalls
    drive(1'b1, 5'd1, 5'd2, 5'd0, 32'h55, 32'h0, C_LOAD, 32'h3000);
    step();
    chk("t4_load_rd_e", {27'b0, ex.rd}, 32'd0);
    drive(1'b1, 5'd0, 5'd0, 5'd10, 32'h66, 32'h0, C_ALU, 32'h3004);
    #1;
    chk("t4_ready_d", {31'b0, dec.ready}, 32'd1);
    step();
    chk("t4_rd1_e", ex.rd1, 32'h66);
    chk("t4_no_bubble", {16'b0, bubble_cnt}, 32'd1);

    // Flush coinciding with hazard and stall
    drive(1'b1, 5'd1, 5'd2, 5'd12, 32'h77, 32'h0, C_LOAD, 32'h4000);
    step();
    chk("t5_load_valid", {31'b0, ex.valid}, 32'd1);
    drive(1'b1, 5'd12, 5'd2, 5'd13, 32'h99, 32'h0, C_ALU, 32'h4004);
    ex.ready = 1'b0;
    flush_e  = 1'b1;
    step();
    flush_e  = 1'b0;
    ex.ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 32'h0);
    #1;
    chk("t5_valid_e", {31'b0, ex.valid}, 32'd0);
    chk("t5_ctrl_e", {16'b0, ex.ctrl}, 32'd0);
    chk("t5_no_capture", ex.rd1, 32'h77);
    chk("t5_no_bubble", {16'b0, bubble_cnt}, 32'd1);
    chk("t5_ready_d", {31'b0, dec.ready}, 32'd1);
    step();
    chk("t5_stays_empty", {31'b0, ex.valid}, 32'd0);
    drive(1'b1, 5'd1, 5'd2, 5'd14, 32'h88, 32'h0, C_ALU, 32'h5000);
    step();
    chk("t5_refill_valid", {31'b0, ex.valid}, 32'd1);
    chk("t5_refill_rd1", ex.rd1, 32'h88);

    // Writeback bypass on rs1
    drive(1'b1, 5'd3, 5'd2, 5'd11, 32'h0, 32'h0, C_ALU, 32'h6000);
    wb_we   = 1'b1;
    wb_rd   = 5'd3;
    wb_data = 32'hAB;
    step();
    chk("t6_bypass_rs1", ex.rd1, exp_bp1);
    // Writes to x0 are never forwarded
    drive(1'b1, 5'd0, 5'd2, 5'd11, 32'h5, 32'h0, C_ALU, 32'h6004);
    wb_rd   = 5'd0;
    wb_data = 32'hCD;
    step();
    chk("t6_bypass_x0", ex.rd1, 32'h5);
    // Bypass on rs2
    drive(1'b1, 5'd1, 5'd4, 5'd11, 32'h1, 32'h9, C_ALU, 32'h6008);
    wb_rd   = 5'd4;
    wb_data = 32'hCAFE;
    step();
    chk("t6_bypass_rs2", ex.rd2, exp_bp2);
    wb_we = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 32'h0);

    // Asynchronous reset mid-operation
    drive(1'b1, 5'd1, 5'd2, 5'd15, 32'hDEAD, 32'h0, C_ALU, 32'h7000);
    step();
    chk("t7_pre_valid", {31'b0, ex.valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_valid", {31'b0, ex.valid}, 32'd0);
    chk("t7_async_rd1", ex.rd1, 32'd0);
    chk("t7_async_ready", {31'b0, dec.ready}, 32'd0);
    chk("t7_async_cnt", {16'b0, bubble_cnt}, 32'd0);
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
